// File: rtl/mem_rd_ctrl_if.sv
// Core-side bus for the data read responder: request, write and response signals.
interface mem_rd_ctrl_if #(
  parameter int IN_WIDTH = 16
);
  logic [31:0]         addr;
  logic                re;
  logic                we;
  logic [31:0]         wdata;
  logic [IN_WIDTH-1:0] data_in;
  logic [31:0]         rdata;
  logic                rvalid;
  logic                busy;

  modport master (
    output addr, re, we, wdata, data_in,
    input  rdata, rvalid, busy
  );

  modport slave (
    input  addr, re, we, wdata, data_in,
    output rdata, rvalid, busy
  );
endinterface

// File: rtl/mem_rd_ctrl.sv
// Data-side read responder: serves core loads from a word RAM and from
// synchronized board inputs, answering each accepted read two cycles later.
//
// state | meaning
// IDLE  | waiting for re; latches addr on acceptance
// READ  | RAM / input mux sampled into rdata at end of cycle
// RESP  | rvalid high for this single cycle
module mem_rd_ctrl #(
  parameter int ADDR_WIDTH = 5,
  parameter int IN_WIDTH   = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_rd_ctrl_if.slave  bus
);

  localparam logic [31:0] IN_ADDR  = 32'h0001_0000;
  localparam logic [31:0] CHG_ADDR = 32'h0001_0004;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [31:0]           addr_q;
  logic [31:0]           rdata_q;
  logic [31:0]           rd_mux;
  logic [IN_WIDTH-1:0]   sync1_q, sync2_q, prev_q;
  logic                  chg_q;
  logic                  chg_clr;
  logic                  accept;

  logic [31:0]           mem [2**ADDR_WIDTH];

  assign accept  = (state_q == IDLE) && bus.re;
  assign chg_clr = (state_q == READ) && (addr_q == CHG_ADDR);

  // RAM write port: any state, only for the low 64 KiB window
  always_ff @(posedge clk) begin
    if (bus.we && (bus.addr[31:16] == 16'h0000))
      mem[bus.addr[ADDR_WIDTH+1:2]] <= bus.wdata;
  end

  // Read data source selected by the address latched at acceptance
  always_comb begin
    rd_mux = 32'h0000_0000;
    if (addr_q[31:16] == 16'h0000)
      rd_mux = mem[addr_q[ADDR_WIDTH+1:2]];
    else if (addr_q == IN_ADDR)
      rd_mux = 32'(sync2_q);
    else if (addr_q == CHG_ADDR)
      rd_mux = {31'b0, chg_q};
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // Next-state and response outputs
  always_comb begin
    state_d    = state_q;
    bus.rvalid = 1'b0;
    bus.busy   = 1'b1;
    case (state_q)
      IDLE: begin
        bus.busy = 1'b0;
        if (bus.re)
          state_d = READ;
      end
      READ: state_d = RESP;
      RESP: begin
        bus.rvalid = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request address latch and response data register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= 32'h0000_0000;
      rdata_q <= 32'h0000_0000;
    end else begin
      if (accept)
        addr_q <= bus.addr;
      if (state_q == READ)
        rdata_q <= rd_mux;
    end
  end

  assign bus.rdata = rdata_q;

  // Board input synchronizer and change flag; a new change beats a status-read clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      chg_q   <= 1'b0;
    end else begin
      sync1_q <= bus.data_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      if (sync2_q != prev_q)
        chg_q <= 1'b1;
      else if (chg_clr)
        chg_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_rd_ctrl.sv
// Directed bench for mem_rd_ctrl: table of write/read vectors plus
// hand-written sequences for same-cycle access, input change flag,
// back-to-back requests and reset during a read.
module tb_mem_rd_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  mem_rd_ctrl_if #(.IN_WIDTH(16)) bus ();

  mem_rd_ctrl #(.ADDR_WIDTH(5), .IN_WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        do_we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    bus.addr  = a;
    bus.wdata = d;
    bus.we    = 1'b1;
    tick();
    bus.we    = 1'b0;
  endtask

  // Issue one read, wait (bounded) for rvalid, check latency, return to IDLE.
  task automatic do_read(input logic [31:0] a, output logic [31:0] d);
    int cyc;
    bus.addr = a;
    bus.re   = 1'b1;
    tick();
    bus.re   = 1'b0;
    cyc = 0;
    d   = 32'hxxxx_xxxx;
    while (cyc < 6) begin
      tick();
      cyc++;
      if (bus.rvalid) break;
    end
    check("read_latency", 32'(cyc), 32'd1);
    check("rvalid_seen", {31'b0, bus.rvalid}, 32'd1);
    d = bus.rdata;
    tick();
  endtask

  initial begin
    logic [31:0] rd;
    logic [5:0]  busy_pat;
    int          pulses;

    vecs[0] = '{1'b1, 32'h0000_0008, 32'hCAFE_0001, 32'hCAFE_0001};
    vecs[1] = '{1'b1, 32'h0000_0000, 32'h1111_1111, 32'h1111_1111};
    vecs[2] = '{1'b1, 32'h0000_007C, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[3] = '{1'b0, 32'h0000_0008, 32'h0,         32'hCAFE_0001};
    vecs[4] = '{1'b0, 32'h0000_0088, 32'h0,         32'hCAFE_0001};
    vecs[5] = '{1'b1, 32'h0001_0008, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[6] = '{1'b0, 32'h0002_0000, 32'h0,         32'h0000_0000};
    vecs[7] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         32'h0000_0000};
    vecs[8] = '{1'b1, 32'h0000_0003, 32'h0000_00A5, 32'h0000_00A5};
    vecs[9] = '{1'b0, 32'h0000_FF7C, 32'h0,         32'hDEAD_BEEF};

    bus.addr = '0; bus.re = 1'b0; bus.we = 1'b0; bus.wdata = '0; bus.data_in = '0;

    // Reset held with inputs toggling
    for (int i = 0; i < 4; i++) begin
      bus.data_in = 16'(i * 16'h3C3C + 1);
      bus.re      = i[0];
      @(negedge clk);
    end
    check("rst_rdata", bus.rdata, 32'h0);
    check("rst_rvalid", {31'b0, bus.rvalid}, 32'h0);
    check("rst_busy", {31'b0, bus.busy}, 32'h0);
    bus.re = 1'b0; bus.data_in = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(); tick(); tick();
    do_read(32'h0001_0004, rd);
    check("rst_chg", rd, 32'h0);

    // Table-driven write/read vectors
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].do_we) do_write(vecs[i].addr, vecs[i].wdata);
      do_read(vecs[i].addr, rd);
      check($sformatf("vec%0d", i), rd, vecs[i].exp);
    end

    // Same-cycle write and read to word 1 returns new data; alias 0x84
    do_write(32'h0000_0004, 32'h0);
    bus.addr = 32'h0000_0004; bus.wdata = 32'h0000_1234;
    bus.we = 1'b1; bus.re = 1'b1;
    tick();
    bus.we = 1'b0; bus.re = 1'b0;
    tick();
    check("wr_rd_same_rvalid", {31'b0, bus.rvalid}, 32'h1);
    check("wr_rd_same_data", bus.rdata, 32'h0000_1234);
    tick();
    do_read(32'h0000_0084, rd);
    check("alias_0x84", rd, 32'h0000_1234);

    // Board inputs and change flag
    bus.data_in = 16'hA5A5;
    tick(); tick(); tick();
    do_read(32'h0001_0000, rd);
    check("data_in_val", rd, 32'h0000_A5A5);
    do_read(32'h0001_0004, rd);
    check("chg_first", rd, 32'h1);
    do_read(32'h0001_0004, rd);
    check("chg_cleared", rd, 32'h0);
    // Change timed so its set lands on the clearing edge of a status read
    bus.data_in = 16'h5A5A;
    tick();
    do_read(32'h0001_0004, rd);
    check("chg_coincide_ret", rd, 32'h0);
    do_read(32'h0001_0004, rd);
    check("chg_set_wins", rd, 32'h1);
    do_read(32'h0001_0004, rd);
    check("chg_after", rd, 32'h0);

    // re held high for 6 cycles
    pulses = 0;
    bus.addr = 32'h0000_0008;
    bus.re = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      busy_pat[5-i] = bus.busy;
      if (bus.rvalid) pulses++;
    end
    bus.re = 1'b0;
    check("b2b_busy_pat", {26'b0, busy_pat}, 32'b110110);
    check("b2b_pulses", 32'(pulses), 32'd2);
    tick(); tick();

    // Reset asserted during READ aborts the response
    bus.addr = 32'h0000_0008;
    bus.re = 1'b1;
    tick();
    bus.re = 1'b0;
    check("mid_busy_before", {31'b0, bus.busy}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", {31'b0, bus.busy}, 32'h0);
    check("mid_rst_rdata", bus.rdata, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.rvalid || bus.busy) pulses++;
    end
    check("mid_rst_no_resp", 32'(pulses), 32'd0);
    do_read(32'h0002_0000, rd);
    check("unmapped", rd, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
